// File: rtl/fu_result_arbiter_if.sv
// Result-arbiter bus: two FU result inputs, ROB handshake/flush, and the
// registered broadcast bus toward the ROB and reservation stations.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

interface fu_result_arbiter_if #(
  parameter int GPR_W     = 64,
  parameter int ROB_IDX_W = `ROB_IDX_SIZE,
  parameter int CNT_W     = 16
);
  logic                 in_alu_valid;
  logic                 out_alu_ready;
  logic [GPR_W-1:0]     in_alu_value;
  logic [ROB_IDX_W-1:0] in_alu_rob_index;
  logic                 in_alu_set_nzcv;
  logic [3:0]           in_alu_nzcv;

  logic                 in_ls_valid;
  logic                 out_ls_ready;
  logic [GPR_W-1:0]     in_ls_value;
  logic [ROB_IDX_W-1:0] in_ls_rob_index;
  logic                 in_ls_set_nzcv;
  logic [3:0]           in_ls_nzcv;

  logic                 in_rob_ready;
  logic                 in_flush;

  logic                 out_bcast_done;
  logic [ROB_IDX_W-1:0] out_bcast_index;
  logic [GPR_W-1:0]     out_bcast_value;
  logic                 out_bcast_set_nzcv;
  logic [3:0]           out_bcast_nzcv;
  logic                 out_bcast_src;
  logic [CNT_W-1:0]     out_conflict_cnt;

  modport master (
    output in_alu_valid, in_alu_value, in_alu_rob_index, in_alu_set_nzcv, in_alu_nzcv,
    output in_ls_valid, in_ls_value, in_ls_rob_index, in_ls_set_nzcv, in_ls_nzcv,
    output in_rob_ready, in_flush,
    input  out_alu_ready, out_ls_ready,
    input  out_bcast_done, out_bcast_index, out_bcast_value, out_bcast_set_nzcv,
    input  out_bcast_nzcv, out_bcast_src, out_conflict_cnt
  );

  modport slave (
    input  in_alu_valid, in_alu_value, in_alu_rob_index, in_alu_set_nzcv, in_alu_nzcv,
    input  in_ls_valid, in_ls_value, in_ls_rob_index, in_ls_set_nzcv, in_ls_nzcv,
    input  in_rob_ready, in_flush,
    output out_alu_ready, out_ls_ready,
    output out_bcast_done, out_bcast_index, out_bcast_value, out_bcast_set_nzcv,
    output out_bcast_nzcv, out_bcast_src, out_conflict_cnt
  );
endinterface

// File: rtl/fu_result_arbiter.sv
// Round-robin arbiter sharing the ROB broadcast bus between the ALU and LS
// result FIFOs; registered broadcast, flush support, saturating conflict count.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

module fu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_flush,
  input  logic         in_push,
  input  logic         in_pop,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_head,
  output logic         out_ready,
  output logic         out_nempty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [PW:0]             count;
  logic                    do_push, do_pop;

  // Ready comes from the registered count only: a full FIFO refuses a push
  // even if it pops on the same edge.
  assign out_ready  = count < (PW+1)'(DEPTH);
  assign out_nempty = count != '0;
  assign do_push    = in_push & out_ready & ~in_flush;
  assign do_pop     = in_pop & out_nempty & ~in_flush;
  assign out_head   = mem[rd_ptr];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (in_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge in_clk) begin
    if (do_push) mem[wr_ptr] <= in_data;
  end
endmodule

module fu_result_arbiter #(
  parameter int GPR_W      = 64,
  parameter int ROB_IDX_W  = `ROB_IDX_SIZE,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input logic               in_clk,
  input logic               in_rst_n,
  fu_result_arbiter_if.slave bus
);
  localparam int NUM_FU = 2;
  localparam int ENT_W  = GPR_W + ROB_IDX_W + 5;

  logic [NUM_FU-1:0][ENT_W-1:0] wdata, head;
  logic [NUM_FU-1:0]            push, pop, ready, nempty;
  logic                         eligible, both, gnt, last_grant;
  logic [ENT_W-1:0]             sel;

  logic                 bc_done, bc_set, bc_src;
  logic [ROB_IDX_W-1:0] bc_index;
  logic [GPR_W-1:0]     bc_value;
  logic [3:0]           bc_nzcv;
  logic [CNT_W-1:0]     conflict_cnt;

  // Lane 0 = ALU, lane 1 = LS; the lane number doubles as out_bcast_src.
  assign wdata[0] = {bus.in_alu_value, bus.in_alu_rob_index, bus.in_alu_set_nzcv, bus.in_alu_nzcv};
  assign wdata[1] = {bus.in_ls_value, bus.in_ls_rob_index, bus.in_ls_set_nzcv, bus.in_ls_nzcv};
  assign push     = {bus.in_ls_valid, bus.in_alu_valid};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    fu_result_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .in_clk    (in_clk),
      .in_rst_n  (in_rst_n),
      .in_flush  (bus.in_flush),
      .in_push   (push[i]),
      .in_pop    (pop[i]),
      .in_data   (wdata[i]),
      .out_head  (head[i]),
      .out_ready (ready[i]),
      .out_nempty(nempty[i])
    );
  end

  assign both     = &nempty;
  assign eligible = bus.in_rob_ready & ~bus.in_flush & (|nempty);
  assign gnt      = both ? ~last_grant : nempty[1];
  assign sel      = head[gnt];

  always_comb begin
    pop = '0;
    if (eligible) pop[gnt] = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      bc_done      <= 1'b0;
      bc_index     <= '0;
      bc_value     <= '0;
      bc_set       <= 1'b0;
      bc_nzcv      <= '0;
      bc_src       <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      bc_done <= eligible;
      if (eligible) begin
        {bc_value, bc_index, bc_set, bc_nzcv} <= sel;
        bc_src <= gnt;
      end
      // Round-robin pointer only moves when there was a real contest.
      if (eligible && both) begin
        last_grant <= gnt;
        if (~&conflict_cnt) conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  assign bus.out_alu_ready      = ready[0];
  assign bus.out_ls_ready       = ready[1];
  assign bus.out_bcast_done     = bc_done;
  assign bus.out_bcast_index    = bc_index;
  assign bus.out_bcast_value    = bc_value;
  assign bus.out_bcast_set_nzcv = bc_set;
  assign bus.out_bcast_nzcv     = bc_nzcv;
  assign bus.out_bcast_src      = bc_src;
  assign bus.out_conflict_cnt   = conflict_cnt;
endmodule
